// File: rtl/p_encode_dat.sv
// -----------------------------------------------------------------------------
// p_encode_dat
// Transmit-side packer for the piston data/control word. Each accepted slice
// data beat is packed as {ctrl, data} (ctrl in the MSBs) and handed to the
// output through a 2-entry skid buffer. The buffer gives full throughput and
// keeps ready/valid registered on both sides.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous active-low reset
//   k_ctrl     in   SELOU    new control selector value
//   k_ctrl_we  in   1        load k_ctrl into the sticky ctrl register
//   i_dat      in   DW       slice data beat
//   i_valid    in   1        i_dat valid
//   i_ready    out  1        block accepts a beat this cycle (registered)
//   t_kp_dat   out  TW       packed {ctrl,data} word (registered)
//   t_valid    out  1        t_kp_dat valid (registered)
//   t_ready    in   1        downstream accepts t_kp_dat
//   beat_cnt   out  32       beats delivered (only with P_ENCODE_BEATCNT_EN)
//
// Configuration macro: P_ENCODE_BEATCNT_EN. When it is defined, a wrapping
// 32-bit delivered-beat counter is added.
// -----------------------------------------------------------------------------
module p_encode_dat #(
    parameter int SELOU  = 4,
    parameter int SLICES = 4,
    parameter int PERIN  = 16,
    localparam int DW    = SLICES * PERIN,
    localparam int TW    = SELOU + DW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SELOU-1:0] k_ctrl,
    input  logic             k_ctrl_we,
    input  logic [DW-1:0]    i_dat,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [TW-1:0]    t_kp_dat,
    output logic             t_valid,
    input  logic             t_ready
`ifdef P_ENCODE_BEATCNT_EN
    ,
    output logic [31:0]      beat_cnt
`endif
);

    // ONE: only the output register holds a beat.
    // TWO: the output register and the skid register both hold a beat.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    occ_t             state_r;
    occ_t             state_s;
    logic [SELOU-1:0] ctrl_r;
    logic [SELOU-1:0] ctrl_eff_s;
    logic [TW-1:0]    word_s;
    logic [TW-1:0]    out_r;
    logic [TW-1:0]    out_s;
    logic [TW-1:0]    skid_r;
    logic [TW-1:0]    skid_s;
    logic             valid_r;
    logic             valid_s;
    logic             ready_r;
    logic             ready_s;
    logic             in_fire_s;
    logic             out_fire_s;

    // A ctrl write in the same cycle as a beat applies to that beat.
    assign ctrl_eff_s = k_ctrl_we ? k_ctrl : ctrl_r;
    assign word_s     = {ctrl_eff_s, i_dat};
    assign in_fire_s  = i_valid && ready_r;
    assign out_fire_s = valid_r && t_ready;

    assign i_ready  = ready_r;
    assign t_kp_dat = out_r;
    assign t_valid  = valid_r;

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next occupancy, next buffer contents and next ready.
    always_comb begin
        state_s = state_r;
        out_s   = out_r;
        skid_s  = skid_r;
        valid_s = valid_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_s = ST_ONE;
                    out_s   = word_s;
                    valid_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && !out_fire_s) begin
                    state_s = ST_TWO;
                    skid_s  = word_s;
                end else if (out_fire_s && !in_fire_s) begin
                    state_s = ST_EMPTY;
                    valid_s = 1'b0;
                end else if (in_fire_s && out_fire_s) begin
                    state_s = ST_ONE;
                    out_s   = word_s;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // ready is low in TWO, so only a pop can happen here.
                if (out_fire_s) begin
                    state_s = ST_ONE;
                    out_s   = skid_r;
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                state_s = ST_EMPTY;
                valid_s = 1'b0;
            end
        endcase
        // Ready follows the occupancy that the next state will have.
        ready_s = (state_s != ST_TWO);
    end

    // Output register, skid register, valid and ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r   <= '0;
            skid_r  <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            out_r   <= out_s;
            skid_r  <= skid_s;
            valid_r <= valid_s;
            ready_r <= ready_s;
        end
    end

    // Sticky control selector, written independently of data traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r <= '0;
        end else if (k_ctrl_we) begin
            ctrl_r <= k_ctrl;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

`ifdef P_ENCODE_BEATCNT_EN
    logic [31:0] beat_cnt_r;

    // Delivered-beat counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_r <= 32'd0;
        end else if (out_fire_s) begin
            beat_cnt_r <= beat_cnt_r + 32'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt = beat_cnt_r;
`endif

endmodule

// File: tb/tb_p_encode_dat.sv
// -----------------------------------------------------------------------------
// tb_p_encode_dat
// Self-checking bench for p_encode_dat. The reference model is a queue of the
// packed words held inside the block, plus a sticky ctrl value. The expected
// outputs follow from the queue: t_valid is high when the queue is non-empty,
// t_kp_dat is the queue head, and i_ready is high when fewer than two words
// are held. Inputs change on the falling edge. Outputs are checked on the
// falling edge, where they are stable.
// -----------------------------------------------------------------------------
module tb_p_encode_dat;

    localparam int DW = 64;
    localparam int TW = 68;

    logic          clk;
    logic          reset_n;
    logic [3:0]    k_ctrl;
    logic          k_ctrl_we;
    logic [DW-1:0] i_dat;
    logic          i_valid;
    logic          i_ready;
    logic [TW-1:0] t_kp_dat;
    logic          t_valid;
    logic          t_ready;
`ifdef P_ENCODE_BEATCNT_EN
    logic [31:0]   beat_cnt;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] q[$];
    logic [3:0]    ctrl_m;
    int            delivered;

    p_encode_dat dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .k_ctrl    (k_ctrl),
        .k_ctrl_we (k_ctrl_we),
        .i_dat     (i_dat),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .t_kp_dat  (t_kp_dat),
        .t_valid   (t_valid),
        .t_ready   (t_ready)
`ifdef P_ENCODE_BEATCNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the DUT outputs with the model, then apply one cycle of stimulus
    // to both the DUT and the model.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic we,
                         input logic [3:0] kc, input logic tr);
        logic in_f;
        logic out_f;
        @(negedge clk);
        check("t_valid", {67'd0, t_valid}, {67'd0, q.size() > 0});
        check("i_ready", {67'd0, i_ready}, {67'd0, q.size() < 2});
        if (q.size() > 0) begin
            check("t_kp_dat", t_kp_dat, q[0]);
        end
`ifdef P_ENCODE_BEATCNT_EN
        check("beat_cnt", {36'd0, beat_cnt}, TW'(delivered));
`endif
        i_valid   = v;
        i_dat     = d;
        k_ctrl_we = we;
        k_ctrl    = kc;
        t_ready   = tr;
        in_f  = v && (q.size() < 2);
        out_f = tr && (q.size() > 0);
        if (out_f) begin
            void'(q.pop_front());
            delivered++;
        end
        if (in_f) begin
            q.push_back({(we ? kc : ctrl_m), d});
        end
        if (we) begin
            ctrl_m = kc;
        end
    endtask

    task automatic idle(input logic tr);
        drive(1'b0, 64'd0, 1'b0, 4'd0, tr);
    endtask

    initial begin
        reset_n   = 1'b0;
        k_ctrl    = 4'd0;
        k_ctrl_we = 1'b0;
        i_dat     = 64'd0;
        i_valid   = 1'b0;
        t_ready   = 1'b0;
        ctrl_m    = 4'd0;
        delivered = 0;

        // Reset: outputs cleared and ready low while held.
        repeat (5) begin
            @(negedge clk);
            check("rst_t_valid", {67'd0, t_valid}, 68'd0);
            check("rst_t_kp_dat", t_kp_dat, 68'd0);
            check("rst_i_ready", {67'd0, i_ready}, 68'd0);
        end
        reset_n = 1'b1;
        idle(1'b1);

        // Pack: ctrl written first, then a beat.
        drive(1'b0, 64'd0, 1'b1, 4'hA, 1'b1);
        drive(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        check("pack_word", t_kp_dat, 68'hA_0123_4567_89AB_CDEF);
        check("pack_valid", {67'd0, t_valid}, 68'd1);

        // Same-cycle ctrl write wins, and then sticks.
        drive(1'b0, 64'd0, 1'b1, 4'd3, 1'b1);
        drive(1'b1, 64'h1111_2222_3333_4444, 1'b1, 4'd5, 1'b1);
        @(posedge clk);
        #1;
        check("same_cyc_ctrl", {64'd0, t_kp_dat[67:64]}, 68'd5);
        drive(1'b1, 64'h5555_6666_7777_8888, 1'b0, 4'd9, 1'b1);
        @(posedge clk);
        #1;
        check("sticky_ctrl", {64'd0, t_kp_dat[67:64]}, 68'd5);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: two beats fill the buffer, and ready drops.
        drive(1'b1, 64'hD0D0_D0D0_D0D0_D0D0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 64'hD1D1_D1D1_D1D1_D1D1, 1'b1, 4'd7, 1'b0);
        drive(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 4'd0, 1'b0);
        idle(1'b0);
        check("bp_hold_d0", t_kp_dat, {4'd5, 64'hD0D0_D0D0_D0D0_D0D0});
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Streaming at full rate.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 4'($urandom), 1'b1);
        end
        idle(1'b1);
        idle(1'b1);

        // Streaming with random valid, ready and ctrl writes.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                  4'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
        end

        // Mid-flight reset while the buffer is full.
        drive(1'b1, 64'hAAAA_0000_AAAA_0000, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 64'hBBBB_0000_BBBB_0000, 1'b0, 4'd0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_t_valid", {67'd0, t_valid}, 68'd0);
        check("mid_rst_t_kp_dat", t_kp_dat, 68'd0);
        check("mid_rst_i_ready", {67'd0, i_ready}, 68'd0);
`ifdef P_ENCODE_BEATCNT_EN
        check("mid_rst_beat_cnt", {36'd0, beat_cnt}, 68'd0);
`endif
        q.delete();
        ctrl_m    = 4'd0;
        delivered = 0;
        t_ready   = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
        end
        // ctrl must be back to zero after the reset.
        drive(1'b1, 64'hCAFE_F00D_CAFE_F00D, 1'b0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_ctrl", {64'd0, t_kp_dat[67:64]}, 68'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "time limit reached");
    end

endmodule
